// File: rtl/smi_flit_scale_xn.sv
// SMI flit width upscaler: packs ScaleFactor narrow input flits into one wide output flit.
// Optional build macro SMI_FLIT_SCALE_ZERO_PAD_EN zeroes the unused upper lanes on an early end-of-frame.
module smi_flit_scale_xn #(
  parameter int FlitWidth      = 4,
  parameter int ScaleFactor    = 8,
  parameter int ScaleIndexSize = 3
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               smiInReady,
  input  logic [7:0]                         smiInEofc,
  input  logic [FlitWidth*8-1:0]             smiInData,
  output logic                               smiInStop,
  output logic                               smiOutReady,
  output logic [7:0]                         smiOutEofc,
  output logic [FlitWidth*ScaleFactor*8-1:0] smiOutData,
  input  logic                               smiOutStop
);

  localparam int                        LaneBits  = FlitWidth * 8;
  localparam int                        OutBits   = LaneBits * ScaleFactor;
  localparam logic [ScaleIndexSize-1:0] LastLane  = ScaleIndexSize'(ScaleFactor - 1);
  localparam logic [7:0]                FlitBytes = 8'(FlitWidth);

  logic [ScaleIndexSize-1:0] cnt;
  logic [OutBits-1:0]        asm_q;
  logic [OutBits-1:0]        merged;
  logic [OutBits-1:0]        out_flit;
  logic [7:0]                eofc_clamped;
  logic [7:0]                lane_bytes;
  logic [7:0]                next_eofc;
  logic                      in_fire;
  logic                      out_fire;
  logic                      complete;

  // Stall the producer only while a finished flit is waiting on a stalled consumer.
  assign smiInStop = smiOutReady & smiOutStop;
  assign in_fire   = smiInReady & ~smiInStop;
  assign out_fire  = smiOutReady & ~smiOutStop;
  assign complete  = in_fire & ((cnt == LastLane) | (smiInEofc != 8'd0));

  assign eofc_clamped = (smiInEofc > FlitBytes) ? FlitBytes : smiInEofc;
  assign lane_bytes   = 8'(cnt) * FlitBytes;
  assign next_eofc    = (smiInEofc != 8'd0) ? (lane_bytes + eofc_clamped) : 8'd0;

  // NOTE: every variable gets its default before any conditional write, so no latch is inferred.
  always_comb begin
    merged = asm_q;
    for (int i = 0; i < ScaleFactor; i++) begin
      if (cnt == ScaleIndexSize'(i)) merged[i*LaneBits +: LaneBits] = smiInData;
    end
  end

`ifdef SMI_FLIT_SCALE_ZERO_PAD_EN
  always_comb begin
    out_flit = merged;
    for (int i = 0; i < ScaleFactor; i++) begin
      if (ScaleIndexSize'(i) > cnt) out_flit[i*LaneBits +: LaneBits] = '0;
    end
  end
`else
  // Upper lanes keep whatever earlier frames left there; Eofc tells the consumer what is valid.
  assign out_flit = merged;
`endif

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      // NOTE: the assembly register is reset too, so nothing from an aborted frame can leak out.
      asm_q       <= '0;
      smiOutReady <= 1'b0;
      smiOutEofc  <= 8'd0;
      smiOutData  <= '0;
    end else begin
      if (in_fire) begin
        asm_q <= merged;
        cnt   <= complete ? '0 : cnt + ScaleIndexSize'(1);
      end
      if (complete) begin
        smiOutReady <= 1'b1;
        smiOutEofc  <= next_eofc;
        smiOutData  <= out_flit;
      end else if (out_fire) begin
        smiOutReady <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_smi_flit_scale_xn.sv
// Self-checking bench for smi_flit_scale_xn with FlitWidth=4, ScaleFactor=4 (16-byte output).
// Expected output flits are queued as stimulus is driven and compared when the DUT hands them over.
module tb_smi_flit_scale_xn;

  localparam logic [127:0] FullMask  = {128{1'b1}};
  localparam logic [127:0] Lane0Mask = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;

  typedef struct {
    logic [127:0] data;
    logic [127:0] mask;
    logic [7:0]   eofc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         smiInReady = 1'b0;
  logic [7:0]   smiInEofc = 8'd0;
  logic [31:0]  smiInData = 32'd0;
  logic         smiInStop;
  logic         smiOutReady;
  logic [7:0]   smiOutEofc;
  logic [127:0] smiOutData;
  logic         smiOutStop = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   out_idx = 0;
  exp_t exp_q[$];

  smi_flit_scale_xn #(
    .FlitWidth     (4),
    .ScaleFactor   (4),
    .ScaleIndexSize(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .smiInReady (smiInReady),
    .smiInEofc  (smiInEofc),
    .smiInData  (smiInData),
    .smiInStop  (smiInStop),
    .smiOutReady(smiOutReady),
    .smiOutEofc (smiOutEofc),
    .smiOutData (smiOutData),
    .smiOutStop (smiOutStop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic [127:0] d, input logic [127:0] m, input logic [7:0] e);
    exp_t x;
    x.data = d;
    x.mask = m;
    x.eofc = e;
    exp_q.push_back(x);
  endtask

  // Single-flit frame: lane 0 carries the flit; upper lanes are zero only with padding enabled.
  task automatic push_single(input logic [31:0] d, input logic [7:0] e);
`ifdef SMI_FLIT_SCALE_ZERO_PAD_EN
    push_exp({96'd0, d}, FullMask, e);
`else
    push_exp({96'd0, d}, Lane0Mask, e);
`endif
  endtask

  // Pops one expected flit per output transfer (Ready=1, Stop=0 seen just before the edge).
  task automatic monitor_loop();
    exp_t x;
    forever begin
      @(negedge clk);
      if (rstn && smiOutReady && !smiOutStop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output #%0d: got data=%h eofc=%0d, expected no output",
                   out_idx, smiOutData, smiOutEofc);
        end else begin
          x = exp_q.pop_front();
          if ((smiOutData & x.mask) !== (x.data & x.mask)) begin
            errors++;
            $display("FAIL out_data #%0d: got %h expected %h (mask %h)",
                     out_idx, smiOutData, x.data, x.mask);
          end
          checks++;
          if (smiOutEofc !== x.eofc) begin
            errors++;
            $display("FAIL out_eofc #%0d: got %0d expected %0d", out_idx, smiOutEofc, x.eofc);
          end
        end
        out_idx++;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge on which the flit transferred.
  task automatic send(input logic [31:0] d, input logic [7:0] e);
    bit done = 1'b0;
    smiInReady = 1'b1;
    smiInData  = d;
    smiInEofc  = e;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!smiInStop) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: flit %h not accepted within 64 cycles, expected acceptance", d);
    end
  endtask

  task automatic drain();
    smiInReady = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d flits still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    smiOutStop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({smiOutReady, smiOutEofc, smiOutData, smiInStop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b eofc=%0d data=%h stop=%b, expected all 0",
               smiOutReady, smiOutEofc, smiOutData, smiInStop);
    end
    @(negedge clk);
    rstn       = 1'b1;
    smiOutStop = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_flit();
    push_exp(128'h0F0E0D0C_0B0A0908_07060504_03020100, FullMask, 8'd0);
    send(32'h03020100, 8'd0);
    send(32'h07060504, 8'd0);
    send(32'h0B0A0908, 8'd0);
    checks++;
    if (smiOutReady !== 1'b0) begin
      errors++;
      $display("FAIL full_early_ready: got %b after 3 flits, expected 0", smiOutReady);
    end
    send(32'h0F0E0D0C, 8'd0);
    smiInReady = 1'b0;
    checks++;
    if (smiOutReady !== 1'b1) begin
      errors++;
      $display("FAIL full_latency: got ready=%b after 4th transfer, expected 1", smiOutReady);
    end
    drain();
  endtask

  task automatic test_short_frame();
    push_exp(128'h0F0E0D0C_0B0A0908_07060504_03020100, FullMask, 8'd0);
`ifdef SMI_FLIT_SCALE_ZERO_PAD_EN
    push_exp(128'h00000000_00000000_BBBBBBBB_AAAAAAAA, FullMask, 8'd7);
`else
    push_exp(128'h0F0E0D0C_0B0A0908_BBBBBBBB_AAAAAAAA, FullMask, 8'd7);
`endif
    send(32'h03020100, 8'd0);
    send(32'h07060504, 8'd0);
    send(32'h0B0A0908, 8'd0);
    send(32'h0F0E0D0C, 8'd0);
    send(32'hAAAAAAAA, 8'd0);
    send(32'hBBBBBBBB, 8'd3);
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [31:0] d;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      d = 32'hC0DE0000 + 32'(i);
      push_single(d, 8'd4);
      send(d, 8'd4);
    end
    smiInReady = 1'b0;
    checks++;
    if (cyc - c0 != 10) begin
      errors++;
      $display("FAIL single_flit_rate: got %0d cycles for 10 frames, expected 10", cyc - c0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    smiOutStop = 1'b1;
    push_single(32'h11111111, 8'd4);
    push_single(32'h22222222, 8'd2);
    send(32'h11111111, 8'd4);
    smiInData = 32'h22222222;
    smiInEofc = 8'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (smiInStop !== 1'b1 || smiOutEofc !== 8'd4 || smiOutData[31:0] !== 32'h11111111) begin
        errors++;
        $display("FAIL bp_hold: got stop=%b eofc=%0d lane0=%h, expected 1/4/11111111",
                 smiInStop, smiOutEofc, smiOutData[31:0]);
      end
    end
    @(posedge clk);
    #1;
    smiOutStop = 1'b0;
    @(posedge clk);
    #1;
    smiInReady = 1'b0;
    checks++;
    if (smiOutReady !== 1'b1 || smiOutEofc !== 8'd2) begin
      errors++;
      $display("FAIL bp_reload: got ready=%b eofc=%0d after drain+load, expected 1/2",
               smiOutReady, smiOutEofc);
    end
    drain();
  endtask

  task automatic test_illegal_count();
    push_single(32'h12345678, 8'd4);
    send(32'h12345678, 8'd9);
    drain();
  endtask

  task automatic test_reset_mid_frame();
    send(32'hDEADBEEF, 8'd0);
    send(32'hCAFEF00D, 8'd0);
    smiInReady = 1'b0;
    smiOutStop = 1'b1;
    rstn       = 1'b0;
    #2;
    checks++;
    if ({smiOutReady, smiOutEofc, smiOutData, smiInStop} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ready=%b eofc=%0d data=%h stop=%b, expected all 0",
               smiOutReady, smiOutEofc, smiOutData, smiInStop);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn       = 1'b1;
    smiOutStop = 1'b0;
    @(posedge clk);
    #1;
    push_exp(128'h77777777_66666666_55555555_44444444, FullMask, 8'd0);
    send(32'h44444444, 8'd0);
    send(32'h55555555, 8'd0);
    send(32'h66666666, 8'd0);
    send(32'h77777777, 8'd0);
    drain();
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_full_flit();
    test_short_frame();
    test_back_to_back();
    test_backpressure();
    test_illegal_count();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
